inst_fetch: RTL and testbench

Instruction-fetch stage of the MIPS core. Holds the program counter, drives the combinational instruction ROM's word address and select, and captures the returned instruction word into the IF/ID pipeline register together with its PC and a valid bit. It honours decode-stage stalls and execute-stage redirects (branch, jump, `jr`), and keeps a count of instructions delivered.

---
 rtl/inst_fetch_if.sv | 16 +
 rtl/inst_fetch.sv | 114 +++++++++++
 tb/tb_inst_fetch.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bus between the fetch stage and the combinational
// instruction ROM.
//   rom_addr : ROM word address (fetch -> ROM)
//   rom_sel  : ROM enable       (fetch -> ROM)
//   rom_dout : instruction word (ROM -> fetch), same cycle as rom_addr
// Modports: master = fetch stage, slave = ROM.
interface inst_fetch_if #(
  parameter int ROM_ADDR_BITS = 10
);
  logic [ROM_ADDR_BITS-1:0] rom_addr;
  logic                     rom_sel;
  logic [31:0]              rom_dout;

  modport master (output rom_addr, output rom_sel, input rom_dout);
  modport slave  (input rom_addr, input rom_sel, output rom_dout);
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage of the MIPS core.
// Holds the PC, addresses the instruction ROM and captures the returned
// word into the IF/ID register with its PC and a valid bit. Honours
// decode stalls and execute redirects and counts delivered instructions.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   stall        : hold PC and IF/ID
//   redirect     : load redirect_pc (word aligned) and squash the fetch
//   redirect_pc  : redirect target
//   rom          : inst_fetch_if.master (rom_addr, rom_sel, rom_dout)
//   if_pc        : PC of the IF/ID instruction
//   if_instr     : IF/ID instruction word
//   if_valid     : IF/ID holds a real instruction
//   fetch_cnt    : instructions delivered since reset (wraps)
//   halted       : fetch halted on syscall
//
// Optional feature: define FETCH_HALT_ON_SYSCALL_EN to stop fetching
// after a syscall (32'h0000_000C) is delivered. Without it, halted is 0.
module inst_fetch #(
  parameter int                  PC_BITS       = 32,
  parameter int                  ROM_ADDR_BITS = 10,
  parameter logic [PC_BITS-1:0]  RESET_PC      = 32'h0000_3000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_BITS-1:0]  redirect_pc,
  inst_fetch_if.master        rom,
  output logic [PC_BITS-1:0]  if_pc,
  output logic [31:0]         if_instr,
  output logic                if_valid,
  output logic [31:0]         fetch_cnt,
  output logic                halted
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_BITS-1:0]  r_pc;
  logic [PC_BITS-1:0]  r_if_pc;
  logic [31:0]         r_if_instr;
  logic                r_if_valid;
  logic [31:0]         r_fetch_cnt;
  logic                w_capture;
  logic [PC_BITS-1:0]  w_redirect_pc;

  // A real capture happens only in RUN with neither redirect nor stall.
  assign w_capture     = (r_state == S_RUN) && !redirect && !stall;
  assign w_redirect_pc = redirect_pc & {{(PC_BITS-2){1'b1}}, 2'b00};

  // ROM word address is the PC offset from the text base; truncation
  // wraps it at the end of the ROM.
  assign rom.rom_addr = ROM_ADDR_BITS'((r_pc - RESET_PC) >> 2);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
`ifdef FETCH_HALT_ON_SYSCALL_EN
    if (w_capture && (rom.rom_dout == 32'h0000_000C))
      w_state_nxt = S_HALT;
`endif
  end

  // Output logic; rom_sel is also held low during the reset cycle.
  always_comb begin
    rom.rom_sel = (r_state == S_RUN) && !rst;
`ifdef FETCH_HALT_ON_SYSCALL_EN
    halted      = (r_state == S_HALT);
`else
    halted      = 1'b0;
`endif
  end

  // PC, IF/ID register and delivery counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_if_pc     <= '0;
      r_if_instr  <= '0;
      r_if_valid  <= 1'b0;
      r_fetch_cnt <= '0;
    end else if (r_state == S_RUN) begin
      if (redirect) begin
        // Squash the fetch in flight; if_pc keeps its old value.
        r_pc       <= w_redirect_pc;
        r_if_instr <= '0;
        r_if_valid <= 1'b0;
      end else if (w_capture) begin
        r_if_instr  <= rom.rom_dout;
        r_if_pc     <= r_pc;
        r_if_valid  <= 1'b1;
        r_pc        <= r_pc + PC_BITS'(4);
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end else if (!stall) begin
      r_if_valid <= 1'b0;
    end
  end

  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign if_valid  = r_if_valid;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  typedef logic [108:0] vec_t; // {if_pc, if_instr, if_valid, fetch_cnt, rom_addr, rom_sel, halted}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic [31:0] fetch_cnt;
  logic        halted;

  logic [31:0] rom_mem [0:1023];

  inst_fetch_if #(.ROM_ADDR_BITS(10)) bus ();

  assign bus.rom_dout = rom_mem[bus.rom_addr];

  inst_fetch #(
    .PC_BITS      (32),
    .ROM_ADDR_BITS(10),
    .RESET_PC     (32'h0000_3000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .rom        (bus.master),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .if_valid   (if_valid),
    .fetch_cnt  (fetch_cnt),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc, m_if_pc, m_if_instr, m_cnt;
  logic        m_if_valid, m_halt;
  vec_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [9:0] maddr(input logic [31:0] p);
    logic [31:0] d;
    d = (p - 32'h0000_3000) >> 2;
    return d[9:0];
  endfunction

  function automatic vec_t obs();
    return {if_pc, if_instr, if_valid, fetch_cnt, bus.rom_addr, bus.rom_sel, halted};
  endfunction

  // Advances the model by one edge using the current inputs, pushes the
  // expected post-edge outputs, then clocks the DUT.
  task automatic tick();
    logic [31:0] w;
    if (rst) begin
      m_pc = 32'h0000_3000; m_if_pc = '0; m_if_instr = '0;
      m_if_valid = 1'b0; m_cnt = '0; m_halt = 1'b0;
    end else if (!m_halt) begin
      if (redirect) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        m_if_valid = 1'b0; m_if_instr = '0;
      end else if (!stall) begin
        w = rom_mem[maddr(m_pc)];
        m_if_instr = w; m_if_pc = m_pc; m_if_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
`ifdef FETCH_HALT_ON_SYSCALL_EN
        if (w == 32'h0000_000C) m_halt = 1'b1;
`endif
      end
    end else if (!stall) begin
      m_if_valid = 1'b0;
    end
    q.push_back({m_if_pc, m_if_instr, m_if_valid, m_cnt, maddr(m_pc),
                 (!m_halt && !rst), m_halt});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    tick();
    void'(q.pop_front());
    rst = 1'b0;
  endtask

  task automatic test_reset();
    vec_t e;
    rst = 1'b1;
    tick();
    e = q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL reset_vec: got %h want %h", obs(), e);
    end
    n_vec++;
    if ({if_pc, if_instr, if_valid, fetch_cnt, bus.rom_sel, bus.rom_addr} !== {32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 10'h0}) begin
      n_bad++; $display("FAIL reset_const: got pc=%h instr=%h v=%b cnt=%0d sel=%b addr=%h want zeros",
                        if_pc, if_instr, if_valid, fetch_cnt, bus.rom_sel, bus.rom_addr);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.rom_sel !== 1'b1) begin
      n_bad++; $display("FAIL rom_sel_run: got %b want 1", bus.rom_sel);
    end
  endtask

  task automatic test_sequential();
    vec_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      e = q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL seq[%0d]: got %h want %h", i, obs(), e);
      end
      if (i == 2) begin
        n_vec++;
        if ({if_pc, if_instr, fetch_cnt} !== {32'h0000_3008, rom_mem[2], 32'd3}) begin
          n_bad++; $display("FAIL seq_third: got pc=%h instr=%h cnt=%0d want 3008 %h 3",
                            if_pc, if_instr, fetch_cnt, rom_mem[2]);
        end
      end
    end
  endtask

  task automatic test_stall();
    vec_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      stall = (i == 1 || i == 2);
      tick();
      e = q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL stall[%0d]: got %h want %h", i, obs(), e);
      end
      if (i == 2) begin
        n_vec++;
        if ({if_pc, bus.rom_addr, fetch_cnt} !== {32'h0000_3000, 10'h001, 32'd1}) begin
          n_bad++; $display("FAIL stall_hold: got pc=%h addr=%h cnt=%0d want 3000 001 1",
                            if_pc, bus.rom_addr, fetch_cnt);
        end
      end
    end
    n_vec++;
    if ({if_pc, if_instr} !== {32'h0000_3004, rom_mem[1]}) begin
      n_bad++; $display("FAIL stall_resume: got %h/%h want 3004/%h", if_pc, if_instr, rom_mem[1]);
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect();
    vec_t e;
    do_reset();
    tick(); void'(q.pop_front());
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3013;
    tick();
    e = q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL redirect_edge: got %h want %h", obs(), e);
    end
    n_vec++;
    if ({if_valid, bus.rom_addr} !== {1'b0, 10'h004}) begin
      n_bad++; $display("FAIL redirect_bubble: got v=%b addr=%h want 0 004", if_valid, bus.rom_addr);
    end
    stall = 1'b0; redirect = 1'b0;
    tick();
    e = q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL redirect_target: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_wrap();
    vec_t e;
    redirect = 1'b1; redirect_pc = 32'h0000_3FFC;
    tick();
    redirect = 1'b0;
    e = q.pop_front();
    n_vec++;
    if (bus.rom_addr !== 10'h3FF || obs() !== e) begin
      n_bad++; $display("FAIL wrap_last: got %h want %h", obs(), e);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      e = q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL wrap[%0d]: got %h want %h", i, obs(), e);
      end
    end
    n_vec++;
    if ({if_pc, if_instr, bus.rom_addr} !== {32'h0000_4000, rom_mem[0], 10'h001}) begin
      n_bad++; $display("FAIL wrap_pc: got %h/%h/%h want 4000/%h/001", if_pc, if_instr, bus.rom_addr, rom_mem[0]);
    end
  endtask

  task automatic test_syscall();
    vec_t e;
    rom_mem[2] = 32'h0000_000C;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      stall = (i == 4);
      tick();
      e = q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_bad++; $display("FAIL syscall[%0d]: got %h want %h", i, obs(), e);
      end
    end
    stall = 1'b0;
`ifdef FETCH_HALT_ON_SYSCALL_EN
    n_vec++;
    if ({halted, bus.rom_sel, if_valid, fetch_cnt} !== {1'b1, 1'b0, 1'b0, 32'd3}) begin
      n_bad++; $display("FAIL syscall_halt: got h=%b sel=%b v=%b cnt=%0d want 1 0 0 3",
                        halted, bus.rom_sel, if_valid, fetch_cnt);
    end
`else
    n_vec++;
    if ({halted, fetch_cnt} !== {1'b0, 32'd5}) begin
      n_bad++; $display("FAIL syscall_plain: got h=%b cnt=%0d want 0 5", halted, fetch_cnt);
    end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e = q.pop_front();
    n_vec++;
    if (obs() !== e || bus.rom_addr !== 10'h000) begin
      n_bad++; $display("FAIL syscall_rst: got %h want %h", obs(), e);
    end
    rom_mem[2] = 32'h8000_0000 | $urandom;
  endtask

  task automatic test_rst_redirect();
    vec_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(); void'(q.pop_front());
    end
    rst = 1'b1; redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_3100;
    tick();
    e = q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_bad++; $display("FAIL rst_redirect: got %h want %h", obs(), e);
    end
    n_vec++;
    if ({if_pc, if_valid, fetch_cnt, bus.rom_addr} !== {32'h0, 1'b0, 32'h0, 10'h000}) begin
      n_bad++; $display("FAIL rst_redirect_const: got pc=%h v=%b cnt=%0d addr=%h want 0 0 0 000",
                        if_pc, if_valid, fetch_cnt, bus.rom_addr);
    end
    rst = 1'b0; redirect = 1'b0; stall = 1'b0;
  endtask

  initial begin
    // Bit 31 set keeps random words from ever matching syscall.
    for (int i = 0; i < 1024; i++) rom_mem[i] = 32'h8000_0000 | $urandom;
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_syscall();
    test_rst_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
